// File: rtl/credit_consumer.sv
// credit_consumer
//   Gates a valid/ready stream with credits returned by a downstream credit
//   producer. Symbol credits cover receive-buffer space and packet credits
//   cover packet slots. The returned counts arrive as free-running, wrapping
//   16-bit counters. Available credit is (returned + initial - consumed),
//   computed modulo 2^16.
//
// Ports
//   clk             : clock; all state updates on its rising edge
//   reset_n         : synchronous active-low reset
//   symbol_credits  : wrapping count of symbol credits returned downstream
//   packet_credits  : wrapping count of packet credits returned downstream
//   in_valid/in_ready/in_data/in_endofpacket      : upstream sink
//   out_valid/out_ready/out_data/out_endofpacket  : downstream source
//   sym_avail       : current available symbol credits
//   pkt_avail       : current available packet credits

module credit_consumer #(
    parameter int unsigned DATA_WIDTH          = 8,
    parameter int unsigned SYMBOLS_PER_CREDIT  = 1,
    parameter int unsigned SYMBOLS_PER_BEAT    = 1,
    parameter int unsigned USE_SYMBOL_CREDITS  = 1,
    parameter int unsigned USE_PACKET_CREDITS  = 1,
    parameter int unsigned USE_PACKETS         = 1,
    parameter int unsigned INIT_SYMBOL_CREDITS = 16,
    parameter int unsigned INIT_PACKET_CREDITS = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [15:0]           symbol_credits,
    input  logic [15:0]           packet_credits,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_endofpacket,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_endofpacket,
    output logic [15:0]           sym_avail,
    output logic [15:0]           pkt_avail
);

    // A beat covers whole credits, or a credit spans whole beats.
    localparam bit SymWhole = (SYMBOLS_PER_BEAT % SYMBOLS_PER_CREDIT) == 0;
    localparam bit SymFrac  = (SYMBOLS_PER_CREDIT % SYMBOLS_PER_BEAT) == 0;

    localparam logic [15:0] CreditsPerBeat = 16'(SYMBOLS_PER_BEAT / SYMBOLS_PER_CREDIT);
    localparam logic [15:0] SymPerBeat     = 16'(SYMBOLS_PER_BEAT);
    localparam logic [15:0] SymPerCredit   = 16'(SYMBOLS_PER_CREDIT);
    localparam logic [15:0] InitSym        = 16'(INIT_SYMBOL_CREDITS);
    localparam logic [15:0] InitPkt        = 16'(INIT_PACKET_CREDITS);

    localparam bit SymGate = USE_SYMBOL_CREDITS != 0;
    localparam bit PktGate = (USE_PACKETS != 0) && (USE_PACKET_CREDITS != 0);
    localparam bit PktEop  = USE_PACKETS != 0;

    if (!SymWhole && !SymFrac) begin : g_bad_params
        $error("credit_consumer: SYMBOLS_PER_BEAT and SYMBOLS_PER_CREDIT must divide one another");
    end

    typedef enum logic [0:0] {
        StIdle,
        StActive
    } pkt_state_e;

    pkt_state_e  state_q, state_d;
    logic [15:0] sym_in_q, pkt_in_q;
    logic [15:0] sym_used_q, sym_used_d;
    logic [15:0] pkt_used_q, pkt_used_d;
    logic [15:0] sym_count_q, sym_count_d;

    logic sym_ok, pkt_ok, ok, eop, beat;

    // Wrapping subtraction is exact because true availability stays below 2^15.
    assign sym_avail = sym_in_q + InitSym - sym_used_q;
    assign pkt_avail = pkt_in_q + InitPkt - pkt_used_q;

    assign eop  = in_endofpacket & PktEop;
    assign beat = in_valid & out_ready & ok;

    assign out_valid       = in_valid & ok;
    assign in_ready        = out_ready & ok;
    assign out_data        = in_data;
    assign out_endofpacket = eop;

    always_comb begin
        sym_ok = 1'b1;
        if (SymGate) begin
            if (SymWhole) begin
                sym_ok = sym_avail >= CreditsPerBeat;
            end else begin
                // Inside an open credit window the credit is already paid for.
                sym_ok = (sym_count_q != 16'd0) || (sym_avail >= 16'd1);
            end
        end

        pkt_ok = 1'b1;
        if (PktGate && (state_q == StIdle)) begin
            pkt_ok = pkt_avail >= 16'd1;
        end

        ok = sym_ok & pkt_ok;
    end

    always_comb begin
        sym_used_d  = sym_used_q;
        pkt_used_d  = pkt_used_q;
        sym_count_d = sym_count_q;
        state_d     = state_q;

        if (beat) begin
            if (SymWhole) begin
                if (SymGate) begin
                    sym_used_d = sym_used_q + CreditsPerBeat;
                end
            end else begin
                if (SymGate && (sym_count_q == 16'd0)) begin
                    sym_used_d = sym_used_q + 16'd1;
                end
                // Window closes when the credit is full or the packet ends.
                if (((sym_count_q + SymPerBeat) == SymPerCredit) || eop) begin
                    sym_count_d = 16'd0;
                end else begin
                    sym_count_d = sym_count_q + SymPerBeat;
                end
            end

            unique case (state_q)
                StIdle: begin
                    if (PktGate) begin
                        pkt_used_d = pkt_used_q + 16'd1;
                    end
                    if (!eop) begin
                        state_d = StActive;
                    end
                end
                StActive: begin
                    if (eop) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sym_in_q    <= 16'd0;
            pkt_in_q    <= 16'd0;
            sym_used_q  <= 16'd0;
            pkt_used_q  <= 16'd0;
            sym_count_q <= 16'd0;
            state_q     <= StIdle;
        end else begin
            sym_in_q    <= symbol_credits;
            pkt_in_q    <= packet_credits;
            sym_used_q  <= sym_used_d;
            pkt_used_q  <= pkt_used_d;
            sym_count_q <= sym_count_d;
            state_q     <= state_d;
        end
    end

endmodule

// File: doc/credit_consumer.md
CREDIT_CONSUMER -- requirements
Module: credit_consumer

Interface
REQ-001 Parameter DATA_WIDTH, 8, width of the data bus.
REQ-002 Parameter SYMBOLS_PER_CREDIT, 1, symbols covered by one symbol credit.
REQ-003 Parameter SYMBOLS_PER_BEAT, 1, symbols carried per accepted beat.
REQ-004 Parameter USE_SYMBOL_CREDITS, 1, when 0 the symbol credits never gate traffic.
REQ-005 Parameter USE_PACKET_CREDITS, 1, when 0 the packet credits never gate traffic.
REQ-006 Parameter USE_PACKETS, 1, when 0 in_endofpacket is ignored and treated as 0.
REQ-007 Parameter INIT_SYMBOL_CREDITS, 16, symbol credits granted at reset (receiver buffer depth in credits).
REQ-008 Parameter INIT_PACKET_CREDITS, 4, packet credits granted at reset.
REQ-009 clk  input  1  sole clock; all state updates on its rising edge.
REQ-010 reset_n  input  1  synchronous, active-low reset.
REQ-011 symbol_credits  input  16  free-running, wrapping count of symbol credits returned by the downstream credit producer.
REQ-012 packet_credits  input  16  free-running, wrapping count of packet credits returned by the downstream credit producer.
REQ-013 in_valid / in_ready / in_data / in_endofpacket  input / output / input [DATA_WIDTH] / input  upstream streaming sink.
REQ-014 out_valid / out_ready / out_data / out_endofpacket  output / input / output [DATA_WIDTH] / output  downstream streaming source.
REQ-015 sym_avail  output  16  current available symbol credits.
REQ-016 pkt_avail  output  16  current available packet credits.

Function
REQ-017 The block SHALL register symbol_credits and packet_credits once (sym_in_q, pkt_in_q); no combinational path from the credit inputs to any output.
REQ-018 The block SHALL keep 16-bit consumed counters sym_used and pkt_used, with sym_avail = sym_in_q + INIT_SYMBOL_CREDITS - sym_used and pkt_avail = pkt_in_q + INIT_PACKET_CREDITS - pkt_used, all modulo 2^16.
REQ-019 Credit counters SHALL wrap 0xFFFF->0x0000 with no special handling; true availability never exceeds 32767, and the block relies on this.
REQ-020 The gate "ok" SHALL be a combinational function of registered state only; out_valid = in_valid & ok, in_ready = out_ready & ok, out_data = in_data, out_endofpacket = in_endofpacket & USE_PACKETS.
REQ-021 A beat is out_valid & out_ready.
REQ-022 Symbol case A (SYMBOLS_PER_BEAT % SYMBOLS_PER_CREDIT == 0): each beat consumes N = SYMBOLS_PER_BEAT/SYMBOLS_PER_CREDIT credits; symbol term of ok = sym_avail >= N.
REQ-023 Symbol case B (otherwise, SYMBOLS_PER_CREDIT % SYMBOLS_PER_BEAT == 0): a 16-bit sym_count tracks symbols in the open credit window; a beat with sym_count == 0 consumes 1 credit; symbol term of ok = (sym_count != 0) | (sym_avail >= 1).
REQ-024 In case B, sym_count SHALL reset to 0 when sym_count + SYMBOLS_PER_BEAT == SYMBOLS_PER_CREDIT or on an eop beat; otherwise it advances by SYMBOLS_PER_BEAT per beat.
REQ-025 The packet FSM SHALL have states IDLE (between packets) and ACTIVE (inside a packet); reset state IDLE.
REQ-026 In IDLE the packet term of ok = pkt_avail >= 1; a beat without eop consumes 1 packet credit and moves to ACTIVE; a beat with eop (single-beat packet) consumes 1 credit and stays IDLE.
REQ-027 In ACTIVE the packet term of ok = 1; an eop beat returns to IDLE; no credit is consumed.
REQ-028 When USE_PACKETS = 0 or USE_PACKET_CREDITS = 0, the packet term SHALL be 1 and pkt_used SHALL not change; when USE_SYMBOL_CREDITS = 0, the symbol term SHALL be 1 and sym_used SHALL not change.
REQ-029 A credit return and a consuming beat in the same cycle SHALL both take effect; a credit consumed at edge k is reflected in sym_avail/ok from cycle k+1; returned credits reach ok two cycles after the input changes.
REQ-030 Any illegal parameter combination (neither divisibility holds) SHALL be flagged by an elaboration-time error.

Reset
REQ-031 On reset_n low at a rising edge, sym_in_q, pkt_in_q, sym_used, pkt_used and sym_count SHALL clear to 0, the FSM SHALL enter IDLE, and the block SHALL thereby reach sym_avail = INIT_SYMBOL_CREDITS and pkt_avail = INIT_PACKET_CREDITS.
REQ-032 Reset mid-packet SHALL abandon the packet (IDLE) with no credit restoration beyond the INIT values; the downstream producer is reset together with this block.

Verification
REQ-033 Defaults, credit inputs held at 0, continuous in_valid/out_ready, one 20-beat packet -> exactly 16 beats pass; ok is low from the cycle after beat 16; sym_avail = 0 and pkt_avail = 3.
REQ-034 Continuing REQ-033, symbol_credits stepped to 4 -> 4 more beats pass, starting 2 cycles after the step; eop on beat 20 -> FSM is IDLE and pkt_avail = 3.
REQ-035 Defaults, 5 single-beat eop packets with symbol_credits = 0x100 -> 4 pass; the 5th stalls until packet_credits increments to 1, then passes 2 cycles later.
REQ-036 SYMBOLS_PER_CREDIT = 4, SYMBOLS_PER_BEAT = 1, INIT_SYMBOL_CREDITS = 2, packets of 3 beats -> 2 packets pass (each consumes 1 symbol credit via eop rollover) and the third stalls.
REQ-037 symbol_credits wraps 0xFFFE->0x0002 while sym_used = 0xFFFE -> sym_avail goes from 16 to 20, with no spurious stall or over-grant.
REQ-038 reset_n asserted for one cycle while ACTIVE with sym_used = 9 -> next cycle sym_avail = 16, pkt_avail = 4, FSM = IDLE, and out_valid follows in_valid.
